// File: rtl/ex_hilo_muldiv.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// Multi-cycle MULT/MULTU, 32-step restoring DIV/DIVU, and MTHI/MTLO/MFHI/MFLO service.
module ex_hilo_muldiv #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Valid_in,
    input  logic        Flush_in,
    input  logic        Mult_in,
    input  logic        Multu_in,
    input  logic        Div_in,
    input  logic        Divu_in,
    input  logic        Mthi_in,
    input  logic        Mtlo_in,
    input  logic        Mfhi_in,
    input  logic        Mflo_in,
    input  logic [31:0] Operand_a,
    input  logic [31:0] Operand_b,
    output logic        Stall_out,
    output logic [31:0] Move_data_out,
    output logic [31:0] Hi_out,
    output logic [31:0] Lo_out,
    output logic        Div_by_zero,
    output logic        Busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DIV_FIX} state_t;

    localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_CYCLES - 1);

    state_t      state_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] opa_q;      // multiplicand, or dividend/quotient shift register
    logic [31:0] opb_q;      // multiplier, or divisor magnitude
    logic [31:0] rem_q;
    logic [4:0]  cnt_q;
    logic        signed_q;
    logic        neg_quo_q, neg_rem_q;

    logic        idle, req_div, req_mul, req_any, b_zero;
    logic        start_div, start_mul, own_op;
    logic [63:0] mul_a_ext, mul_b_ext, product;
    logic [32:0] rem_shift, diff;
    logic [31:0] abs_a, abs_b, quo_fix, rem_fix;

    assign idle    = (state_q == S_IDLE);
    assign req_div = Div_in | Divu_in;
    assign req_mul = Mult_in | Multu_in;
    assign req_any = req_div | req_mul | Mthi_in | Mtlo_in | Mfhi_in | Mflo_in;
    assign b_zero  = (Operand_b == 32'd0);

    assign start_div = idle & Valid_in & ~Flush_in & req_div & ~b_zero;
    assign start_mul = idle & Valid_in & ~Flush_in & ~req_div & req_mul;

    // DIV has priority over DIVU, so Div_in alone selects signed handling.
    assign abs_a = (Div_in & Operand_a[31]) ? -Operand_a : Operand_a;
    assign abs_b = (Div_in & Operand_b[31]) ? -Operand_b : Operand_b;

    // Sign-extending into 64 bits lets one unsigned multiply serve both MULT and MULTU.
    assign mul_a_ext = {{32{signed_q & opa_q[31]}}, opa_q};
    assign mul_b_ext = {{32{signed_q & opb_q[31]}}, opb_q};
    assign product   = mul_a_ext * mul_b_ext;

    assign rem_shift = {rem_q, opa_q[31]};
    assign diff      = rem_shift - {1'b0, opb_q};

    assign quo_fix = neg_quo_q ? -opa_q : opa_q;
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;

    // On the final cycle the held instruction is the running op itself; anything else must wait.
    assign own_op = (state_q == S_MUL) ? req_mul : req_div;

    always_comb begin
        Stall_out = 1'b0;
        if (!reset && !Flush_in) begin
            case (state_q)
                S_IDLE:    Stall_out = start_div | start_mul;
                S_MUL:     Stall_out = (cnt_q != 5'd0) | (Valid_in & req_any & ~own_op);
                S_DIV:     Stall_out = 1'b1;
                S_DIV_FIX: Stall_out = Valid_in & req_any & ~own_op;
                default:   Stall_out = 1'b0;
            endcase
        end
    end

    assign Div_by_zero   = ~reset & idle & Valid_in & ~Flush_in & req_div & b_zero;
    assign Move_data_out = Mfhi_in ? hi_q : (Mflo_in ? lo_q : 32'd0);
    assign Hi_out        = hi_q;
    assign Lo_out        = lo_q;
    assign Busy          = ~idle;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
            rem_q     <= 32'd0;
            cnt_q     <= 5'd0;
            signed_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (Flush_in) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_div) begin
                        opa_q     <= abs_a;
                        opb_q     <= abs_b;
                        rem_q     <= 32'd0;
                        signed_q  <= Div_in;
                        neg_quo_q <= Div_in & (Operand_a[31] ^ Operand_b[31]);
                        neg_rem_q <= Div_in & Operand_a[31];
                        cnt_q     <= 5'd31;
                        state_q   <= S_DIV;
                    end else if (start_mul) begin
                        opa_q    <= Operand_a;
                        opb_q    <= Operand_b;
                        signed_q <= Mult_in;
                        cnt_q    <= MUL_CNT_INIT;
                        state_q  <= S_MUL;
                    end else if (Valid_in && !req_div && !req_mul) begin
                        if (Mthi_in) begin
                            hi_q <= Operand_a;
                        end else if (Mtlo_in) begin
                            lo_q <= Operand_a;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == 5'd0) begin
                        hi_q    <= product[63:32];
                        lo_q    <= product[31:0];
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                S_DIV: begin
                    if (!diff[32]) begin
                        rem_q <= diff[31:0];
                        opa_q <= {opa_q[30:0], 1'b1};
                    end else begin
                        rem_q <= rem_shift[31:0];
                        opa_q <= {opa_q[30:0], 1'b0};
                    end
                    if (cnt_q == 5'd0) begin
                        state_q <= S_DIV_FIX;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                S_DIV_FIX: begin
                    lo_q    <= quo_fix;
                    hi_q    <= rem_fix;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_hilo_muldiv.sv
// Directed bench for ex_hilo_muldiv: hand-computed HI/LO results, stall lengths and edge cases.
module tb_ex_hilo_muldiv;

    logic        clock = 1'b0;
    logic        reset;
    logic        Valid_in, Flush_in;
    logic        Mult_in, Multu_in, Div_in, Divu_in;
    logic        Mthi_in, Mtlo_in, Mfhi_in, Mflo_in;
    logic [31:0] Operand_a, Operand_b;
    logic        Stall_out, Div_by_zero, Busy;
    logic [31:0] Move_data_out, Hi_out, Lo_out;

    int n_cmp = 0;
    int n_err = 0;

    ex_hilo_muldiv #(.MUL_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .Valid_in(Valid_in), .Flush_in(Flush_in),
        .Mult_in(Mult_in), .Multu_in(Multu_in), .Div_in(Div_in), .Divu_in(Divu_in),
        .Mthi_in(Mthi_in), .Mtlo_in(Mtlo_in), .Mfhi_in(Mfhi_in), .Mflo_in(Mflo_in),
        .Operand_a(Operand_a), .Operand_b(Operand_b), .Stall_out(Stall_out),
        .Move_data_out(Move_data_out), .Hi_out(Hi_out), .Lo_out(Lo_out),
        .Div_by_zero(Div_by_zero), .Busy(Busy)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clr();
        Valid_in = 0; Flush_in = 0;
        Mult_in = 0; Multu_in = 0; Div_in = 0; Divu_in = 0;
        Mthi_in = 0; Mtlo_in = 0; Mfhi_in = 0; Mflo_in = 0;
        Operand_a = 0; Operand_b = 0;
    endtask

    // Inputs are already presented; count stalled cycles until Stall_out drops (bounded).
    task automatic count_stalls(output int stalls);
        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (!Stall_out) break;
            stalls++;
            @(negedge clock);
        end
    endtask

    // kind: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
    task automatic muldiv(input string tag, input int kind, input logic [31:0] a, input logic [31:0] b,
                          input int exp_stalls, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int stalls;
        @(negedge clock);
        clr();
        Valid_in = 1; Operand_a = a; Operand_b = b;
        case (kind)
            0: Mult_in = 1;
            1: Multu_in = 1;
            2: Div_in = 1;
            default: Divu_in = 1;
        endcase
        count_stalls(stalls);
        @(negedge clock);
        clr();
        #1;
        check_val({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        check_val({tag, "_hi"}, Hi_out, exp_hi);
        check_val({tag, "_lo"}, Lo_out, exp_lo);
        check_val({tag, "_busy"}, 32'(Busy), 32'd0);
        $display("%s a=0x%08h b=0x%08h stalls=%0d hi=0x%08h lo=0x%08h", tag, a, b, stalls, Hi_out, Lo_out);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        clr();
        reset = 1;
        repeat (2) @(negedge clock);
        reset = 0;
        #1;
        check_val("rst_stall", 32'(Stall_out), 32'd0);
        check_val("rst_busy", 32'(Busy), 32'd0);
        check_val("rst_hi", Hi_out, 32'd0);
        check_val("rst_lo", Lo_out, 32'd0);
        check_val("rst_move", Move_data_out, 32'd0);
        check_val("rst_dbz", 32'(Div_by_zero), 32'd0);
        $display("reset done");

        // MTHI then MFHI, never stalling
        @(negedge clock); clr(); Valid_in = 1; Mthi_in = 1; Operand_a = 32'h12345678;
        #1; check_val("mthi_stall", 32'(Stall_out), 32'd0);
        @(negedge clock); clr(); Valid_in = 1; Mfhi_in = 1;
        #1; check_val("mfhi_stall", 32'(Stall_out), 32'd0);
        check_val("mfhi_data", Move_data_out, 32'h12345678);
        $display("mthi/mfhi data=0x%08h", Move_data_out);

        // Valid_in low: op flags ignored
        @(negedge clock); clr(); Mult_in = 1; Operand_a = 3; Operand_b = 3;
        #1; check_val("novalid_stall", 32'(Stall_out), 32'd0);
        @(negedge clock); clr();
        #1; check_val("novalid_busy", 32'(Busy), 32'd0);
        $display("valid-low mult ignored busy=%0d", Busy);

        muldiv("mult",     0, 32'hFFFFFFFF, 32'd5, 2, 32'hFFFFFFFF, 32'hFFFFFFFB);
        muldiv("multu",    1, 32'hFFFFFFFF, 32'd5, 2, 32'h00000004, 32'hFFFFFFFB);
        muldiv("mult_min", 0, 32'h80000000, 32'h80000000, 2, 32'h40000000, 32'h00000000);
        muldiv("div",      2, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        muldiv("divu",     3, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        muldiv("div_negb", 2, 32'd7, 32'hFFFFFFFE, 33, 32'd1, 32'hFFFFFFFD);
        muldiv("div_min",  2, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000);

        // Divide by zero leaves HI/LO alone and pulses for one cycle
        @(negedge clock); clr(); Valid_in = 1; Mthi_in = 1; Operand_a = 32'hA;
        @(negedge clock); clr(); Valid_in = 1; Mtlo_in = 1; Operand_a = 32'hB;
        @(negedge clock); clr(); Valid_in = 1; Div_in = 1; Operand_a = 32'd9; Operand_b = 32'd0;
        #1; check_val("dbz_pulse", 32'(Div_by_zero), 32'd1);
        check_val("dbz_stall", 32'(Stall_out), 32'd0);
        @(negedge clock); clr();
        #1; check_val("dbz_pulse_end", 32'(Div_by_zero), 32'd0);
        check_val("dbz_hi", Hi_out, 32'hA);
        check_val("dbz_lo", Lo_out, 32'hB);
        check_val("dbz_busy", 32'(Busy), 32'd0);
        $display("div by zero hi=0x%08h lo=0x%08h", Hi_out, Lo_out);

        // DIVU 1000/10 with MFLO arriving in cycle 10: held until the quotient lands
        @(negedge clock); clr(); Valid_in = 1; Divu_in = 1; Operand_a = 32'd1000; Operand_b = 32'd10;
        stalls = 0;
        for (int i = 1; i <= 64; i++) begin
            if (i == 10) begin
                clr(); Valid_in = 1; Mflo_in = 1;
            end
            #1;
            if (!Stall_out) break;
            stalls++;
            @(negedge clock);
        end
        check_val("mflo_wait_stalls", 32'(stalls), 32'd34);
        check_val("mflo_wait_data", Move_data_out, 32'd100);
        check_val("mflo_wait_hi", Hi_out, 32'd0);
        $display("divu with mflo stalls=%0d data=%0d", stalls, Move_data_out);

        // Flush in cycle 5 of a DIV
        @(negedge clock); clr(); Valid_in = 1; Div_in = 1; Operand_a = 32'd50; Operand_b = 32'd3;
        repeat (4) @(negedge clock);
        Flush_in = 1;
        #1; check_val("flush_busy_before", 32'(Busy), 32'd1);
        check_val("flush_stall", 32'(Stall_out), 32'd0);
        @(negedge clock); clr();
        #1; check_val("flush_busy_after", 32'(Busy), 32'd0);
        check_val("flush_hi", Hi_out, 32'd0);
        check_val("flush_lo", Lo_out, 32'd100);
        $display("flush mid-div busy=%0d hi=0x%08h lo=0x%08h", Busy, Hi_out, Lo_out);

        // Reset in the middle of a MULT
        @(negedge clock); clr(); Valid_in = 1; Mult_in = 1; Operand_a = 32'd3; Operand_b = 32'd4;
        @(negedge clock);
        reset = 1;
        #1; check_val("rstmul_stall_in_reset", 32'(Stall_out), 32'd0);
        @(negedge clock); reset = 0; clr();
        #1; check_val("rstmul_hi", Hi_out, 32'd0);
        check_val("rstmul_lo", Lo_out, 32'd0);
        check_val("rstmul_busy", 32'(Busy), 32'd0);
        check_val("rstmul_stall", 32'(Stall_out), 32'd0);
        $display("reset mid-mult hi=0x%08h lo=0x%08h busy=%0d", Hi_out, Lo_out, Busy);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
